// File: rtl/frame_seq_pkg.sv
// Shared types and counter widths for the frame mode sequencer.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2,
    SKIP  = 2'd3
  } state_t;

  // "edge" is a reserved word, so the edge-path select bit is edge_sel
  typedef struct packed {
    logic horiz;
    logic edge_sel;
  } mode_t;

  localparam int LOAD_CNT_W = 8;
  localparam int SKIP_CNT_W = 4;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability counter; req moves only after the
// synced vector has held still long enough.
module switch_debouncer #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  output logic [N-1:0] req
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 2);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  cand;
  logic [CW-1:0] cnt;

  // Counter saturates at DEBOUNCE_CYCLES-2 so req lands 2+DEBOUNCE_CYCLES after a switch edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      req   <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        req <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_mode_sequencer.sv
// Switches between RGB and edge pixel paths only at frame boundaries,
// strobing the writer address reload and blanking the priming frame(s).
module frame_mode_sequencer
  import frame_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1024,
  parameter int LOAD_PULSE_CYCLES = 4,
  parameter int SKIP_FRAMES       = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSW_EDGE,
  input  logic       iSW_HORIZ,
  input  logic       iFVAL,
  input  logic       iDVAL_RGB,
  input  logic       iDVAL_EDGE,
  output logic       oSEL_EDGE,
  output logic       oHORIZ,
  output logic       oDVAL,
  output logic       oWR_LOAD,
  output logic [1:0] oSTATE,
  output logic [7:0] oSWITCH_CNT
);

  localparam logic [LOAD_CNT_W-1:0] LOAD_INIT = LOAD_CNT_W'(LOAD_PULSE_CYCLES - 1);
  localparam logic [SKIP_CNT_W-1:0] SKIP_INIT = SKIP_CNT_W'(SKIP_FRAMES);

  logic [1:0] req_vec;
  mode_t      req;
  logic       fval_q;
  logic       fe;

  state_t                state, state_n;
  mode_t                 active, active_n;
  logic                  wr_load, wr_load_n;
  logic                  gate, gate_n;
  logic [LOAD_CNT_W-1:0] load_cnt, load_cnt_n;
  logic [SKIP_CNT_W-1:0] skip_cnt, skip_cnt_n;
  logic [7:0]            switch_cnt, switch_cnt_n;
  logic [7:0]            switch_cnt_inc;

  switch_debouncer #(
    .N               (2),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk (iCLK),
    .rst (iRST),
    .sw  ({iSW_HORIZ, iSW_EDGE}),
    .req (req_vec)
  );

  assign req            = req_vec;
  assign fe             = fval_q & ~iFVAL;
  assign switch_cnt_inc = (switch_cnt == 8'hFF) ? switch_cnt : switch_cnt + 8'd1;

  // Next-state logic; req changes arriving in LOAD/SKIP wait until RUN re-examines them
  always_comb begin
    state_n      = state;
    active_n     = active;
    wr_load_n    = wr_load;
    gate_n       = gate;
    load_cnt_n   = load_cnt;
    skip_cnt_n   = skip_cnt;
    switch_cnt_n = switch_cnt;
    case (state)
      RUN: begin
        if (req != active) state_n = ARMED;
      end
      ARMED: begin
        if (req == active) begin
          state_n = RUN;
        end else if (fe) begin
          active_n   = req;
          wr_load_n  = 1'b1;
          gate_n     = 1'b0;
          load_cnt_n = LOAD_INIT;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt == '0) begin
          wr_load_n = 1'b0;
          if (SKIP_FRAMES == 0) begin
            state_n      = RUN;
            gate_n       = 1'b1;
            switch_cnt_n = switch_cnt_inc;
          end else begin
            state_n    = SKIP;
            skip_cnt_n = SKIP_INIT;
          end
        end else begin
          load_cnt_n = load_cnt - 1'b1;
        end
      end
      SKIP: begin
        if (fe) begin
          if (skip_cnt <= SKIP_CNT_W'(1)) begin
            skip_cnt_n   = '0;
            state_n      = RUN;
            gate_n       = 1'b1;
            switch_cnt_n = switch_cnt_inc;
          end else begin
            skip_cnt_n = skip_cnt - 1'b1;
          end
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_q     <= 1'b0;
      state      <= RUN;
      active     <= '0;
      wr_load    <= 1'b0;
      gate       <= 1'b1;
      load_cnt   <= '0;
      skip_cnt   <= '0;
      switch_cnt <= '0;
    end else begin
      fval_q     <= iFVAL;
      state      <= state_n;
      active     <= active_n;
      wr_load    <= wr_load_n;
      gate       <= gate_n;
      load_cnt   <= load_cnt_n;
      skip_cnt   <= skip_cnt_n;
      switch_cnt <= switch_cnt_n;
    end
  end

  assign oSEL_EDGE   = active.edge_sel;
  assign oHORIZ      = active.horiz;
  assign oWR_LOAD    = wr_load;
  assign oSTATE      = state;
  assign oSWITCH_CNT = switch_cnt;
  assign oDVAL       = gate & (active.edge_sel ? iDVAL_EDGE : iDVAL_RGB);

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Directed bench: expected FSM transitions and load pulse widths are queued by
// the stimulus and consumed by a monitor; oDVAL is checked every cycle.
module tb_frame_mode_sequencer;

  localparam int SRC_NONE = 0;
  localparam int SRC_RGB  = 1;
  localparam int SRC_EDGE = 2;
  localparam int SRC_ZERO = 3;

  typedef struct {
    logic [1:0] st;
    logic       sel;
    logic       hz;
    logic [7:0] cnt;
  } exp_t;

  logic       iCLK;
  logic       iRST;
  logic       iSW_EDGE;
  logic       iSW_HORIZ;
  logic       iFVAL;
  logic       iDVAL_RGB;
  logic       iDVAL_EDGE;
  logic       oSEL_EDGE;
  logic       oHORIZ;
  logic       oDVAL;
  logic       oWR_LOAD;
  logic [1:0] oSTATE;
  logic [7:0] oSWITCH_CNT;

  int   fpos;
  int   src;
  int   check_cnt;
  int   pass_cnt;
  bit   mon_on;
  exp_t exp_q[$];
  int   load_q[$];

  frame_mode_sequencer #(
    .DEBOUNCE_CYCLES   (8),
    .LOAD_PULSE_CYCLES (4),
    .SKIP_FRAMES       (1)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSW_EDGE    (iSW_EDGE),
    .iSW_HORIZ   (iSW_HORIZ),
    .iFVAL       (iFVAL),
    .iDVAL_RGB   (iDVAL_RGB),
    .iDVAL_EDGE  (iDVAL_EDGE),
    .oSEL_EDGE   (oSEL_EDGE),
    .oHORIZ      (oHORIZ),
    .oDVAL       (oDVAL),
    .oWR_LOAD    (oWR_LOAD),
    .oSTATE      (oSTATE),
    .oSWITCH_CNT (oSWITCH_CNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Frames of 100 active + 20 blank cycles, random data-valid on both paths
  initial begin
    fpos       = 0;
    iFVAL      = 1'b1;
    iDVAL_RGB  = 1'b0;
    iDVAL_EDGE = 1'b0;
    forever begin
      @(posedge iCLK);
      #2;
      fpos       = (fpos + 1) % 120;
      iFVAL      = (fpos < 100);
      iDVAL_RGB  = 1'($urandom_range(0, 1));
      iDVAL_EDGE = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic edge_v, input logic horiz_v);
    iSW_EDGE  = edge_v;
    iSW_HORIZ = horiz_v;
  endtask

  function automatic void expectState(input logic [1:0] st, input logic sel, input logic hz, input logic [7:0] cnt);
    exp_t e;
    e.st  = st;
    e.sel = sel;
    e.hz  = hz;
    e.cnt = cnt;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    logic exp_dval;
    @(negedge iCLK);
    if (src != SRC_NONE) begin
      exp_dval = (src == SRC_RGB)  ? iDVAL_RGB :
                 (src == SRC_EDGE) ? iDVAL_EDGE : 1'b0;
      checkOutput("dval", {7'd0, oDVAL}, {7'd0, exp_dval});
    end
  endtask

  task automatic tickUntil(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (fpos != p && n < 300);
    if (fpos != p) checkOutput("frame_pos_reach", 8'(fpos), 8'(p));
  endtask

  // Monitor: every state change and every completed load pulse consumes a queued expectation
  initial begin
    exp_t e;
    logic [1:0] prev_state;
    int load_width;
    prev_state = 2'd0;
    load_width = 0;
    forever begin
      @(negedge iCLK);
      if (mon_on) begin
        if (oSTATE !== prev_state) begin
          check_cnt++;
          if (exp_q.size() == 0) begin
            $display("[TB] FAIL state_change: got state %0d, expected no transition", oSTATE);
          end else begin
            e = exp_q.pop_front();
            if ({oSTATE, oSEL_EDGE, oHORIZ, oSWITCH_CNT} === {e.st, e.sel, e.hz, e.cnt})
              pass_cnt++;
            else
              $display("[TB] FAIL state_change: got st=%0d sel=%0d hz=%0d cnt=%0d, expected st=%0d sel=%0d hz=%0d cnt=%0d",
                       oSTATE, oSEL_EDGE, oHORIZ, oSWITCH_CNT, e.st, e.sel, e.hz, e.cnt);
          end
          prev_state = oSTATE;
        end
        if (oWR_LOAD === 1'b1) begin
          load_width++;
        end else if (load_width > 0) begin
          check_cnt++;
          if (load_q.size() == 0) begin
            $display("[TB] FAIL load_pulse: got width %0d, expected no pulse", load_width);
          end else if (load_width == load_q[0]) begin
            pass_cnt++;
            void'(load_q.pop_front());
          end else begin
            $display("[TB] FAIL load_pulse: got width %0d, expected %0d", load_width, load_q[0]);
            void'(load_q.pop_front());
          end
          load_width = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    mon_on    = 1'b0;
    src       = SRC_NONE;
    iRST      = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Reset values
    repeat (3) tick();
    checkOutput("rst_sel", {7'd0, oSEL_EDGE}, 8'd0);
    checkOutput("rst_horiz", {7'd0, oHORIZ}, 8'd0);
    checkOutput("rst_load", {7'd0, oWR_LOAD}, 8'd0);
    checkOutput("rst_state", {6'd0, oSTATE}, 8'd0);
    checkOutput("rst_cnt", oSWITCH_CNT, 8'd0);
    iRST   = 1'b0;
    src    = SRC_RGB;
    mon_on = 1'b1;

    // Bounce shorter than the debounce window never reaches req
    for (int i = 0; i < 12; i++) begin
      applyStimulus(~iSW_EDGE, 1'b0);
      repeat (5) tick();
      checkOutput("bounce_state", {6'd0, oSTATE}, 8'd0);
    end
    repeat (15) tick();
    checkOutput("bounce_state_settled", {6'd0, oSTATE}, 8'd0);
    checkOutput("bounce_load", {7'd0, oWR_LOAD}, 8'd0);

    // Cancel before a frame end
    tickUntil(5);
    expectState(2'd1, 1'b0, 1'b0, 8'd0);
    expectState(2'd0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1);
    repeat (10) tick();
    checkOutput("cancel_pre_arm", {6'd0, oSTATE}, 8'd0);
    tick();
    checkOutput("cancel_armed", {6'd0, oSTATE}, 8'd1);
    applyStimulus(1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("cancel_still_armed", {6'd0, oSTATE}, 8'd1);
    tick();
    checkOutput("cancel_run", {6'd0, oSTATE}, 8'd0);
    repeat (15) tick();
    checkOutput("cancel_cnt", oSWITCH_CNT, 8'd0);
    checkOutput("cancel_load", {7'd0, oWR_LOAD}, 8'd0);

    // Mode change mid-frame, then a second change arriving during the skipped frame
    tickUntil(50);
    expectState(2'd1, 1'b0, 1'b0, 8'd0);
    expectState(2'd2, 1'b1, 1'b0, 8'd0);
    expectState(2'd3, 1'b1, 1'b0, 8'd0);
    expectState(2'd0, 1'b1, 1'b0, 8'd1);
    expectState(2'd1, 1'b1, 1'b0, 8'd1);
    expectState(2'd2, 1'b1, 1'b1, 8'd1);
    expectState(2'd3, 1'b1, 1'b1, 8'd1);
    expectState(2'd0, 1'b1, 1'b1, 8'd2);
    load_q.push_back(4);
    load_q.push_back(4);
    applyStimulus(1'b1, 1'b0);
    repeat (10) tick();
    checkOutput("mc_pre_arm", {6'd0, oSTATE}, 8'd0);
    tick();
    checkOutput("mc_armed", {6'd0, oSTATE}, 8'd1);
    tickUntil(100);
    checkOutput("mc_armed_at_end", {6'd0, oSTATE}, 8'd1);
    checkOutput("mc_old_sel", {7'd0, oSEL_EDGE}, 8'd0);
    src = SRC_ZERO;
    tick();
    checkOutput("mc_load_state", {6'd0, oSTATE}, 8'd2);
    checkOutput("mc_load_strobe", {7'd0, oWR_LOAD}, 8'd1);
    checkOutput("mc_new_sel", {7'd0, oSEL_EDGE}, 8'd1);
    tickUntil(105);
    checkOutput("mc_load_done", {7'd0, oWR_LOAD}, 8'd0);
    checkOutput("mc_skip_state", {6'd0, oSTATE}, 8'd3);
    tickUntil(10);
    applyStimulus(1'b1, 1'b1);
    tickUntil(100);
    checkOutput("mc_skip_held", {6'd0, oSTATE}, 8'd3);
    src = SRC_EDGE;
    tick();
    checkOutput("mc_run_state", {6'd0, oSTATE}, 8'd0);
    checkOutput("mc_cnt1", oSWITCH_CNT, 8'd1);
    tick();
    checkOutput("skipchg_rearm", {6'd0, oSTATE}, 8'd1);
    checkOutput("skipchg_old_horiz", {7'd0, oHORIZ}, 8'd0);
    tickUntil(100);
    checkOutput("skipchg_armed_at_end", {6'd0, oSTATE}, 8'd1);
    src = SRC_ZERO;
    tick();
    checkOutput("skipchg_load", {6'd0, oSTATE}, 8'd2);
    checkOutput("skipchg_horiz", {7'd0, oHORIZ}, 8'd1);
    checkOutput("skipchg_strobe", {7'd0, oWR_LOAD}, 8'd1);
    tickUntil(100);
    checkOutput("skipchg_skip", {6'd0, oSTATE}, 8'd3);
    src = SRC_EDGE;
    tick();
    checkOutput("skipchg_run", {6'd0, oSTATE}, 8'd0);
    checkOutput("skipchg_cnt2", oSWITCH_CNT, 8'd2);

    // Reset while the load strobe is high
    tickUntil(20);
    expectState(2'd1, 1'b1, 1'b1, 8'd2);
    expectState(2'd2, 1'b0, 1'b1, 8'd2);
    expectState(2'd0, 1'b0, 1'b0, 8'd0);
    load_q.push_back(2);
    applyStimulus(1'b0, 1'b1);
    tickUntil(100);
    checkOutput("rl_armed", {6'd0, oSTATE}, 8'd1);
    src = SRC_ZERO;
    tick();
    checkOutput("rl_load", {6'd0, oSTATE}, 8'd2);
    checkOutput("rl_strobe", {7'd0, oWR_LOAD}, 8'd1);
    checkOutput("rl_sel", {7'd0, oSEL_EDGE}, 8'd0);
    tick();
    iRST = 1'b1;
    applyStimulus(1'b0, 1'b0);
    src = SRC_RGB;
    tick();
    checkOutput("rl_load_cleared", {7'd0, oWR_LOAD}, 8'd0);
    checkOutput("rl_sel_cleared", {7'd0, oSEL_EDGE}, 8'd0);
    checkOutput("rl_horiz_cleared", {7'd0, oHORIZ}, 8'd0);
    checkOutput("rl_state_cleared", {6'd0, oSTATE}, 8'd0);
    checkOutput("rl_cnt_cleared", oSWITCH_CNT, 8'd0);
    iRST = 1'b0;
    repeat (30) tick();
    checkOutput("rl_idle_state", {6'd0, oSTATE}, 8'd0);

    checkOutput("state_queue_left", 8'(exp_q.size()), 8'd0);
    checkOutput("load_queue_left", 8'(load_q.size()), 8'd0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
